dmem_responder: RTL
===================

Name: dmem_responder

Overview:
Data-memory responder serving the load/store request that the MEM stage issues from its EX/MEM pipe fields: ALU_Result as address, Store_Data, Mem_REn/Mem_WEn and Detail (funct3).
- Holds a byte-addressable RAM.
- Performs sized, aligned loads and stores with configurable access latency.
- Returns sign- or zero-extended load data, or an error, over a valid/ready request and a single-cycle response.
- The MEM stage stalls on busy.

Parameters:
DATA_WIDTH, 64, data and address width.
RAM_SIZE, 16, log2 of RAM capacity in bytes; organised as 2^(RAM_SIZE-3) doublewords.
LATENCY, 1, cycles spent in WAIT between accept and response (0 allowed).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  responder can accept a request.
req_addr  in  DATA_WIDTH  byte address (EX/MEM ALU_Result).
req_wdata  in  DATA_WIDTH  store data, right-aligned (EX/MEM Store_Data).
req_ren  in  1  load request (Mem_REn).
req_wen  in  1  store request (Mem_WEn).
req_funct3  in  3  access size and sign (Detail).
resp_valid  out  1  one-cycle response strobe.
resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
resp_err  out  1  access faulted; valid with resp_valid.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, latency counter=0. RAM contents are not reset.
- Reset asserted mid-operation returns to IDLE immediately. A store not yet committed is dropped; no response is produced.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Transfer occurs on a rising edge with req_valid & req_ready & (req_ren | req_wen).
  - req_valid with both enables low is ignored: no transfer, no response.
  - On transfer, register addr, wdata, funct3, op, and the fault flag.
  - Next state is WAIT if LATENCY>0, else RESP.
- Size encoding: size=funct3[1:0] (0=B, 1=H, 2=W, 3=D); funct3[2]=1 means unsigned load.
- Fault conditions, evaluated at accept:
  - misaligned: addr mod 2^size != 0;
  - out of range: addr[DATA_WIDTH-1:RAM_SIZE] != 0;
  - illegal funct3: store with funct3[2]=1, or load with funct3=3'b111;
  - both req_ren and req_wen high.
- WAIT:
  - req_ready=0.
  - Counter loads LATENCY-1 on entry and decrements each cycle.
  - Transition to RESP when the counter is 0.
- Store commit:
  - Occurs on the edge leaving the final WAIT cycle, or on the accept edge when LATENCY=0.
  - Only when not faulted.
  - Byte-lane mask derived from size and addr[2:0]; unaddressed bytes are unchanged.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - Loads: resp_rdata is the selected lanes shifted to bit 0, sign-extended from the top bit of the size (funct3[2]=0) or zero-extended.
  - Stores and faults: resp_rdata=0; resp_err=fault.
- Latency: accept at edge T gives resp_valid high in the cycle after edge T+LATENCY.
  - Minimum back-to-back issue period is LATENCY+2 cycles.
  - req_ready stays low through RESP; no accept in the response cycle.
- A load following a store to the same address returns the newly stored data (the commit precedes the next accept).
- All outputs are registered except req_ready and busy, which decode from the state register.

Decomposition:
- Additions to the shared pipeline package:
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_D=3, F3_BU=4, F3_HU=5, F3_WU=6;
  - DMEM state enum (IDLE/WAIT/RESP);
  - packed DMEM_Req_t (addr, wdata, ren, wen, funct3), reusable by the MEM stage.
- Natural sub-module: dmem_lane_align, combinational.
  - Store side: byte-mask and shifted write-data generation.
  - Load side: lane extraction and sign/zero extension.
  - Shared by this responder and any future cache.

Test Plan:
- LATENCY=1. SD addr 0x100, data 0x8877665544332211; then LD 0x100 → store response has rdata=0, err=0; load response has rdata=0x8877665544332211; resp_valid exactly 2 cycles after each accept.
- After the above: LB 0x107 → 0xFFFFFFFFFFFFFF88. LBU 0x107 → 0x88. LH 0x106 → 0xFFFFFFFFFFFF8877. LWU 0x104 → 0x88776655.
- SB 0x101 data 0xAB; then LD 0x100 → 0x887766554433AB11 (other lanes untouched).
- LW 0x102 (misaligned); SD 0x10000 (out of range); SD with funct3=3'b100 (illegal); ren and wen both high → each gives err=1, rdata=0; a following LD 0x100 shows RAM unchanged.
- LATENCY=0: req_valid held high continuously with alternating requests → accepts every 2nd cycle, resp_valid in the cycle after each accept, busy=1 exactly in RESP cycles.
- Assert rst_n low during WAIT of SD 0x200 data 0x1 → outputs return to reset values asynchronously, no resp_valid; after release, LD 0x200 returns the prior contents.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared pipeline definitions for the data-memory responder:
// funct3 access codes, size codes, FSM states and the MEM-stage request record.
package dmem_responder_pkg;

  localparam int DMEM_XLEN = 64;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_D  = 3'd3;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [2:0] F3_WU = 3'd6;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic [DMEM_XLEN-1:0] addr;
    logic [DMEM_XLEN-1:0] wdata;
    logic                 ren;
    logic                 wen;
    logic [2:0]           funct3;
  } DMEM_Req_t;

  // Access size (log2 of bytes) carried in the low two funct3 bits.
  function automatic logic [1:0] dmem_size(input logic [2:0] funct3);
    return funct3[1:0];
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between a doubleword memory word and right-aligned
// register data: store byte mask / shifted data, load extraction / extension.
// Assumes eight byte lanes per memory word.
module dmem_lane_align
  import dmem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [2:0]              funct3,
  input  logic [2:0]              offset,
  input  logic [DATA_WIDTH-1:0]   store_data,
  output logic [DATA_WIDTH/8-1:0] byte_mask,
  output logic [DATA_WIDTH-1:0]   wdata_shifted,
  input  logic [DATA_WIDTH-1:0]   load_word,
  output logic [DATA_WIDTH-1:0]   load_data
);

  localparam int NB = DATA_WIDTH / 8;

  logic [5:0]            bit_shift;
  logic [NB-1:0]         base_mask;
  logic [DATA_WIDTH-1:0] lane;
  logic                  sign_en;

  assign bit_shift = {offset, 3'b000};

  // Store side: size-wide mask and data moved up to the addressed lane.
  always_comb begin
    base_mask = '1;
    case (dmem_size(funct3))
      SIZE_B:  base_mask = NB'(1);
      SIZE_H:  base_mask = NB'(3);
      SIZE_W:  base_mask = NB'(15);
      default: base_mask = '1;
    endcase
    byte_mask     = base_mask << offset;
    wdata_shifted = store_data << bit_shift;
  end

  // Load side: move the addressed lane to bit 0, then sign- or zero-extend.
  always_comb begin
    lane    = load_word >> bit_shift;
    sign_en = ~funct3[2];
    case (dmem_size(funct3))
      SIZE_B:  load_data = {{(DATA_WIDTH-8){sign_en & lane[7]}}, lane[7:0]};
      SIZE_H:  load_data = {{(DATA_WIDTH-16){sign_en & lane[15]}}, lane[15:0]};
      SIZE_W:  load_data = {{(DATA_WIDTH-32){sign_en & lane[31]}}, lane[31:0]};
      default: load_data = lane;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: byte-addressable doubleword RAM,
// sized aligned loads/stores, fault detection at accept, programmable latency
// and a registered one-cycle response.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int RAM_SIZE   = 16,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_ren,
  input  logic                  req_wen,
  input  logic [2:0]            req_funct3,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  busy
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int AW    = RAM_SIZE;
  localparam int DEPTH = 2 ** (RAM_SIZE - 3);
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam bit   USE_LIVE = (LATENCY == 0);

  dmem_state_t           state;
  logic [CW-1:0]         cnt;
  logic [AW-1:0]         addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [2:0]            funct3_q;
  logic                  store_q;
  logic                  fault_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  misaligned;
  logic                  out_of_range;
  logic                  illegal;
  logic                  fault_now;
  logic                  accept;
  logic                  to_resp;
  logic                  commit;

  logic [AW-1:0]         acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [2:0]            acc_funct3;
  logic                  acc_store;
  logic                  acc_fault;

  logic [NB-1:0]         byte_mask;
  logic [DATA_WIDTH-1:0] wdata_shifted;
  logic [DATA_WIDTH-1:0] load_word;
  logic [DATA_WIDTH-1:0] load_data;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_ready & req_valid & (req_ren | req_wen);

  // With zero latency the memory is touched on the accept edge, so the live
  // request drives the lane logic; otherwise the captured request does.
  assign to_resp    = USE_LIVE ? accept : ((state == WAIT) && (cnt == '0));
  assign acc_addr   = USE_LIVE ? req_addr[AW-1:0] : addr_q;
  assign acc_wdata  = USE_LIVE ? req_wdata : wdata_q;
  assign acc_funct3 = USE_LIVE ? req_funct3 : funct3_q;
  assign acc_store  = USE_LIVE ? (req_wen & ~req_ren) : store_q;
  assign acc_fault  = USE_LIVE ? fault_now : fault_q;

  // rst_n gating keeps a store from landing while reset is held.
  assign commit    = rst_n & to_resp & acc_store & ~acc_fault;
  assign load_word = mem[acc_addr[AW-1:3]];

  // Classify the incoming request; the result is captured at accept.
  always_comb begin
    misaligned = 1'b0;
    case (dmem_size(req_funct3))
      SIZE_H:  misaligned = req_addr[0];
      SIZE_W:  misaligned = |req_addr[1:0];
      SIZE_D:  misaligned = |req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
    out_of_range = |req_addr[DATA_WIDTH-1:AW];
    illegal      = (req_wen & req_funct3[2]) | (req_ren & (req_funct3 == 3'b111));
    fault_now    = misaligned | out_of_range | illegal | (req_ren & req_wen);
  end

  dmem_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_align (
    .funct3        (acc_funct3),
    .offset        (acc_addr[2:0]),
    .store_data    (acc_wdata),
    .byte_mask     (byte_mask),
    .wdata_shifted (wdata_shifted),
    .load_word     (load_word),
    .load_data     (load_data)
  );

  // RAM byte-lane write; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < NB; b++) begin
        if (byte_mask[b]) begin
          mem[acc_addr[AW-1:3]][b*8 +: 8] <= wdata_shifted[b*8 +: 8];
        end
      end
    end
  end

  // Request FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      store_q    <= 1'b0;
      fault_q    <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q   <= req_addr[AW-1:0];
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            store_q  <= req_wen & ~req_ren;
            fault_q  <= fault_now;
            if (USE_LIVE) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= (acc_store | acc_fault) ? '0 : load_data;
              resp_err   <= acc_fault;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= (acc_store | acc_fault) ? '0 : load_data;
            resp_err   <= acc_fault;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule
